// File: rtl/axis_add_pipe.sv
// axis_add_pipe: AXI-Stream join of two operands, signed add, optional per-packet accumulate.
// Latency: LATENCY cycles from the input pair handshake to OUT_TVALID. Throughput is 1 beat/cycle.
// Backpressure: a held result with OUT_TREADY low stalls every stage, and both input readies drop.
// Optional saturation: define ADD_PIPE_SAT_EN for saturating adds. Otherwise adds wrap modulo 2^WIDTH.
module axis_add_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A_TDATA,
  input  logic             A_TLAST,
  input  logic             A_TVALID,
  output logic             A_TREADY,
  input  logic [WIDTH-1:0] B_TDATA,
  input  logic             B_TLAST,
  input  logic             B_TVALID,
  output logic             B_TREADY,
  output logic [WIDTH-1:0] OUT_TDATA,
  output logic             OUT_TLAST,
  output logic             OUT_TVALID,
  input  logic             OUT_TREADY,
  output logic             BUSY,
  output logic             LAST_ERR
);

  // These are the registered stages that sit ahead of the output register.
  // Index 0 holds the stage-1 sum, and the higher indices are pure delay.
  localparam int NS = LATENCY - 1;

  if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
    $error("axis_add_pipe: LATENCY must be in 2..8");
  end

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] st_dat [NS];
  logic [NS-1:0]    st_vld;
  logic [NS-1:0]    st_last;
  logic [NS-1:0]    st_mode;
  logic [WIDTH-1:0] acc;
  logic             acc_act;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] t_dat;
  logic             t_vld;
  logic             t_last;
  logic             t_mode;

  // This adds two signed values in WIDTH+1 bits, then either wraps the result or clamps it to the signed range.
  function automatic logic [WIDTH-1:0] add_red(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
`ifdef ADD_PIPE_SAT_EN
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    return s[WIDTH-1:0];
  endfunction

  // The pipe stalls globally only when a finished result is waiting for the downstream side.
  assign adv      = ~(OUT_TVALID & ~OUT_TREADY);
  assign A_TREADY = B_TVALID & adv;
  assign B_TREADY = A_TVALID & adv;
  assign accept   = A_TVALID & B_TVALID & adv;

  assign in_sum  = add_red(A_TDATA, B_TDATA);
  assign t_dat   = st_dat[NS-1];
  assign t_vld   = st_vld[NS-1];
  assign t_last  = st_last[NS-1];
  assign t_mode  = st_mode[NS-1];
  assign acc_sum = add_red(acc, t_dat);

  // acc_act tracks open packets, because a partial sum can legitimately be zero.
  assign BUSY = (|st_vld) | OUT_TVALID | acc_act;

  // This block registers the stage-1 sum and shifts the delay stages. Everything holds while adv is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld  <= '0;
      st_last <= '0;
      st_mode <= '0;
      for (int i = 0; i < NS; i++) st_dat[i] <= '0;
    end else if (adv) begin
      st_vld[0]  <= accept;
      st_dat[0]  <= in_sum;
      st_last[0] <= A_TLAST;
      st_mode[0] <= MODE;
      for (int i = 1; i < NS; i++) begin
        st_vld[i]  <= st_vld[i-1];
        st_dat[i]  <= st_dat[i-1];
        st_last[i] <= st_last[i-1];
        st_mode[i] <= st_mode[i-1];
      end
    end
  end

  // The output register takes per-beat results directly. In accumulate mode it folds beats into acc and publishes on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_TDATA  <= '0;
      OUT_TLAST  <= 1'b0;
      OUT_TVALID <= 1'b0;
      acc        <= '0;
      acc_act    <= 1'b0;
    end else if (adv) begin
      // When adv is high, a valid result is being accepted this cycle, so it retires unless replaced below.
      if (OUT_TVALID) OUT_TVALID <= 1'b0;
      if (t_vld) begin
        if (!t_mode) begin
          OUT_TDATA  <= t_dat;
          OUT_TLAST  <= t_last;
          OUT_TVALID <= 1'b1;
        end else if (!t_last) begin
          acc     <= acc_sum;
          acc_act <= 1'b1;
        end else begin
          OUT_TDATA  <= acc_sum;
          OUT_TLAST  <= 1'b1;
          OUT_TVALID <= 1'b1;
          acc        <= '0;
          acc_act    <= 1'b0;
        end
      end
    end
  end

  // LAST_ERR is a sticky flag. It records any accepted pair whose end-of-packet markers disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      LAST_ERR <= 1'b0;
    end else if (accept && (A_TLAST != B_TLAST)) begin
      LAST_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_add_pipe.sv
// This is a directed testbench for axis_add_pipe with WIDTH=32 and LATENCY=3.
// A table of single beats checks data, last, latency and LAST_ERR. Hand-written sequences cover the stall, accumulate and reset cases.
// Expected values for saturation depend on whether ADD_PIPE_SAT_EN is defined.
module tb_axis_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MODE = 1'b0;
  logic [31:0] A_TDATA = '0;
  logic        A_TLAST = 1'b0;
  logic        A_TVALID = 1'b0;
  logic        A_TREADY;
  logic [31:0] B_TDATA = '0;
  logic        B_TLAST = 1'b0;
  logic        B_TVALID = 1'b0;
  logic        B_TREADY;
  logic [31:0] OUT_TDATA;
  logic        OUT_TLAST;
  logic        OUT_TVALID;
  logic        OUT_TREADY = 1'b1;
  logic        BUSY;
  logic        LAST_ERR;

  axis_add_pipe #(.WIDTH(32), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .MODE(MODE),
    .A_TDATA(A_TDATA), .A_TLAST(A_TLAST), .A_TVALID(A_TVALID), .A_TREADY(A_TREADY),
    .B_TDATA(B_TDATA), .B_TLAST(B_TLAST), .B_TVALID(B_TVALID), .B_TREADY(B_TREADY),
    .OUT_TDATA(OUT_TDATA), .OUT_TLAST(OUT_TLAST), .OUT_TVALID(OUT_TVALID), .OUT_TREADY(OUT_TREADY),
    .BUSY(BUSY), .LAST_ERR(LAST_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        la;
    logic        lb;
    logic [31:0] d;
    logic        l;
    logic        err;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // These hold stream stimulus and the captured results for run_stream.
  logic [31:0] st_a [16];
  logic [31:0] st_b [16];
  logic        st_l [16];
  logic [31:0] got_d [$];
  logic        got_l [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // This sends one pair with OUT_TREADY held high. It returns the result, the cycle count to OUT_TVALID, LAST_ERR one cycle after the handshake, and whether OUT_TVALID persisted one more cycle.
  task automatic send1(input vec_t v, output logic [31:0] d, output logic l, output int lat,
                       output logic err1, output logic v_after);
    int k;
    @(negedge clk);
    A_TDATA = v.a; B_TDATA = v.b; A_TLAST = v.la; B_TLAST = v.lb;
    A_TVALID = 1'b1; B_TVALID = 1'b1; OUT_TREADY = 1'b1;
    #1;
    k = 0;
    while (!(A_TREADY && B_TREADY) && k < 10) begin
      @(negedge clk); #1; k++;
    end
    @(posedge clk);
    @(negedge clk);
    A_TVALID = 1'b0; B_TVALID = 1'b0;
    err1 = LAST_ERR;
    lat = 1;
    while (!OUT_TVALID && lat < 10) begin
      @(negedge clk); lat++;
    end
    d = OUT_TDATA;
    l = OUT_TLAST;
    @(negedge clk);
    v_after = OUT_TVALID;
  endtask

  // This streams n beats back to back, with OUT_TREADY low for cycles slo..shi.
  // Ready, stability and result capture are all sampled between edges.
  task automatic run_stream(input int n, input int slo, input int shi);
    int idx;
    logic [31:0] held;
    logic have_held;
    logic done;
    idx = 0; have_held = 1'b0; done = 1'b0;
    got_d.delete(); got_l.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (idx < n) begin
        A_TDATA = st_a[idx]; B_TDATA = st_b[idx];
        A_TLAST = st_l[idx]; B_TLAST = st_l[idx];
        A_TVALID = 1'b1; B_TVALID = 1'b1;
      end else begin
        A_TVALID = 1'b0; B_TVALID = 1'b0;
      end
      OUT_TREADY = !(c >= slo && c <= shi);
      #1;
      if (idx == n && !BUSY) begin
        done = 1'b1;
        break;
      end
      if (!OUT_TREADY && OUT_TVALID) begin
        if (have_held) check("stall_data", {32'd0, OUT_TDATA}, {32'd0, held});
        held = OUT_TDATA; have_held = 1'b1;
        if (idx < n) check("stall_rdy", {62'd0, A_TREADY, B_TREADY}, 64'd0);
      end
      if (OUT_TVALID && OUT_TREADY) begin
        got_d.push_back(OUT_TDATA);
        got_l.push_back(OUT_TLAST);
      end
      if (A_TVALID && B_TVALID && A_TREADY && B_TREADY) idx++;
    end
    @(negedge clk);
    OUT_TREADY = 1'b1; A_TVALID = 1'b0; B_TVALID = 1'b0;
    if (!done) check("stream_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    vec_t        vt [6];
    logic [31:0] d;
    logic        l;
    logic        err1;
    logic        v_after;
    int          lat;

    vt[0] = '{a: 32'd5,          b: 32'd7,          la: 1'b1, lb: 1'b1, d: 32'd12,         l: 1'b1, err: 1'b0};
    vt[1] = '{a: 32'hFFFF_FFFD,  b: 32'hFFFF_FFFC,  la: 1'b0, lb: 1'b0, d: 32'hFFFF_FFF9,  l: 1'b0, err: 1'b0};
    vt[2] = '{a: 32'd100,        b: 32'hFFFF_FF9C,  la: 1'b0, lb: 1'b0, d: 32'd0,          l: 1'b0, err: 1'b0};
`ifdef ADD_PIPE_SAT_EN
    vt[3] = '{a: 32'h7FFF_FFFF,  b: 32'd1,          la: 1'b1, lb: 1'b1, d: 32'h7FFF_FFFF,  l: 1'b1, err: 1'b0};
    vt[4] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  la: 1'b1, lb: 1'b1, d: 32'h8000_0000,  l: 1'b1, err: 1'b0};
`else
    vt[3] = '{a: 32'h7FFF_FFFF,  b: 32'd1,          la: 1'b1, lb: 1'b1, d: 32'h8000_0000,  l: 1'b1, err: 1'b0};
    vt[4] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  la: 1'b1, lb: 1'b1, d: 32'h7FFF_FFFF,  l: 1'b1, err: 1'b0};
`endif
    // This vector has mismatched end-of-packet markers. A_TLAST is authoritative for OUT_TLAST, and LAST_ERR must be set.
    vt[5] = '{a: 32'd3,          b: 32'd4,          la: 1'b1, lb: 1'b0, d: 32'd7,          l: 1'b1, err: 1'b1};

    // Check the reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_vld",  {63'd0, OUT_TVALID}, 64'd0);
    check("rst_dat",  {32'd0, OUT_TDATA},  64'd0);
    check("rst_last", {63'd0, OUT_TLAST},  64'd0);
    check("rst_busy", {63'd0, BUSY},       64'd0);
    check("rst_err",  {63'd0, LAST_ERR},   64'd0);

    // Drive only the A side. It must not be accepted, and nothing must enter the pipe.
    @(negedge clk);
    A_TVALID = 1'b1; A_TDATA = 32'd9; B_TVALID = 1'b0;
    #1;
    check("lone_a_rdy", {63'd0, A_TREADY}, 64'd0);
    repeat (4) @(negedge clk);
    check("lone_busy", {63'd0, BUSY}, 64'd0);
    A_TVALID = 1'b0;

    // Single beats in element-wise mode.
    MODE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send1(vt[i], d, l, lat, err1, v_after);
      check($sformatf("vec%0d_dat", i), {32'd0, d}, {32'd0, vt[i].d});
      check($sformatf("vec%0d_last", i), {63'd0, l}, {63'd0, vt[i].l});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd3);
      check($sformatf("vec%0d_err", i), {63'd0, err1}, {63'd0, vt[i].err});
      if (i == 0) check("vec0_one_cycle", {63'd0, v_after}, 64'd0);
    end
    repeat (3) @(negedge clk);
    check("err_sticky", {63'd0, LAST_ERR}, 64'd1);

    // Reset once to clear LAST_ERR, then stream four beats with a 3-cycle downstream stall.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check("err_cleared", {63'd0, LAST_ERR}, 64'd0);
    MODE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_a[i] = 32'(i + 1);
      st_b[i] = 32'(10 * (i + 1));
      st_l[i] = (i == 3);
    end
    run_stream(4, 3, 5);
    check("stream_cnt", 64'(got_d.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_d.size(); i++)
      check($sformatf("stream_dat%0d", i), {32'd0, got_d[i]}, 64'(11 * (i + 1)));

    // Accumulate mode: a 4-beat packet followed by a single-beat packet.
    MODE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_a[i] = 32'(i + 1); st_b[i] = 32'd1; st_l[i] = (i == 3);
    end
    st_a[4] = 32'd5; st_b[4] = 32'd5; st_l[4] = 1'b1;
    run_stream(5, -1, -1);
    check("acc_cnt", 64'(got_d.size()), 64'd2);
    if (got_d.size() == 2) begin
      check("acc_sum0",  {32'd0, got_d[0]}, 64'd14);
      check("acc_last0", {63'd0, got_l[0]}, 64'd1);
      check("acc_sum1",  {32'd0, got_d[1]}, 64'd10);
      check("acc_last1", {63'd0, got_l[1]}, 64'd1);
    end

    // Reset mid-packet, leaving a partial sum in the accumulator and two beats in flight.
    MODE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A_TDATA = 32'd1; B_TDATA = 32'd1; A_TLAST = 1'b0; B_TLAST = 1'b0;
      A_TVALID = 1'b1; B_TVALID = 1'b1; OUT_TREADY = 1'b1;
    end
    @(negedge clk);
    A_TVALID = 1'b0; B_TVALID = 1'b0;
    #1;
    check("pre_rst_busy", {63'd0, BUSY}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_vld",  {63'd0, OUT_TVALID}, 64'd0);
    check("post_rst_busy", {63'd0, BUSY},       64'd0);
    repeat (4) @(negedge clk);
    check("post_rst_stale", {63'd0, OUT_TVALID}, 64'd0);
    send1('{a: 32'd2, b: 32'd3, la: 1'b1, lb: 1'b1, d: 32'd5, l: 1'b1, err: 1'b0},
          d, l, lat, err1, v_after);
    check("post_rst_sum",  {32'd0, d}, 64'd5);
    check("post_rst_last", {63'd0, l}, 64'd1);
    check("post_rst_lat",  64'(lat),   64'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // This watchdog keeps the run bounded even if a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
